// File: rtl/fetch_seq.sv
// -----------------------------------------------------------------------------
// fetch_seq
// Instruction-fetch sequencer. Owns the program counter, issues one request at
// a time to instruction memory, buffers the single returned word and presents
// it to decode with a valid/ready handshake. Branch/jump redirects reload the
// PC and any fetch already granted for the old path is thrown away.
// Addresses are word addresses, so sequential advance is +1.
// State updates happen on the falling edge of clk (codebase PC convention).
//
// Ports:
//   clk              system clock, state advances on negedge
//   rst_n            asynchronous active-low reset
//   i_redir_valid    control-flow instruction reported this cycle
//   i_redir_type     PC_ADDR_NORMAL / BRANCH / JUMP / UNUSED
//   i_redir_taken    branch outcome, only meaningful for BRANCH
//   i_redir_pc       PC of the control-flow instruction
//   i_redir_offset   signed branch offset in words
//   i_redir_abs      absolute jump target
//   o_imem_req       fetch request
//   o_imem_addr      fetch address
//   i_imem_gnt       request accepted this cycle
//   i_imem_rvalid    response data valid
//   i_imem_rdata     instruction word
//   o_if_valid       instruction available to decode
//   o_if_pc          PC of the presented instruction
//   o_if_instr       presented instruction
//   i_if_ready       decode accepts the presented instruction
//   o_cur_pc         next address to fetch (debug)
// -----------------------------------------------------------------------------
module fetch_seq #(
    parameter int unsigned           ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_redir_valid,
    input  logic [1:0]        i_redir_type,
    input  logic              i_redir_taken,
    input  logic [ADDR_W-1:0] i_redir_pc,
    input  logic [ADDR_W-1:0] i_redir_offset,
    input  logic [ADDR_W-1:0] i_redir_abs,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_gnt,
    input  logic              i_imem_rvalid,
    input  logic [31:0]       i_imem_rdata,
    output logic              o_if_valid,
    output logic [ADDR_W-1:0] o_if_pc,
    output logic [31:0]       o_if_instr,
    input  logic              i_if_ready,
    output logic [ADDR_W-1:0] o_cur_pc
);

    localparam logic [1:0] PC_ADDR_NORMAL = 2'b00;
    localparam logic [1:0] PC_ADDR_BRANCH = 2'b01;
    localparam logic [1:0] PC_ADDR_JUMP   = 2'b10;
    localparam logic [1:0] PC_ADDR_UNUSED = 2'b11;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // DROP means a granted response from an abandoned path is still owed by
    // memory and must be swallowed before the next request goes out.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_if_valid;
    logic [ADDR_W-1:0] r_if_pc;
    logic [31:0]       r_if_instr;

    state_t            w_next_state;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_next_req_pc;
    logic              w_next_if_valid;
    logic [ADDR_W-1:0] w_next_if_pc;
    logic [31:0]       w_next_if_instr;
    logic              w_redir;
    logic [ADDR_W-1:0] w_target;

    // Redirect decode. A plain unsigned add of the offset is the same as a
    // signed add in two's complement, and everything wraps at ADDR_W bits.
    always_comb begin
        w_redir  = 1'b0;
        w_target = i_redir_abs;
        case (i_redir_type)
            PC_ADDR_BRANCH: begin
                w_redir  = i_redir_valid && i_redir_taken;
                w_target = i_redir_pc + ONE + i_redir_offset;
            end
            PC_ADDR_JUMP: begin
                w_redir  = i_redir_valid;
                w_target = i_redir_abs;
            end
            PC_ADDR_NORMAL, PC_ADDR_UNUSED: begin
                w_redir  = 1'b0;
                w_target = i_redir_abs;
            end
            default: begin
                w_redir  = 1'b0;
                w_target = i_redir_abs;
            end
        endcase
    end

    // Next-state and datapath. A redirect always wins the PC and kills the
    // presented instruction; the state it moves to depends on whether a
    // granted response is still outstanding.
    always_comb begin
        w_next_state    = r_state;
        w_next_pc       = r_pc;
        w_next_req_pc   = r_req_pc;
        w_next_if_valid = r_if_valid;
        w_next_if_pc    = r_if_pc;
        w_next_if_instr = r_if_instr;

        case (r_state)
            S_IDLE: begin
                w_next_state = S_REQ;
            end
            S_REQ: begin
                if (w_redir) begin
                    w_next_state = i_imem_gnt ? S_DROP : S_REQ;
                end else if (i_imem_gnt) begin
                    w_next_req_pc = r_pc;
                    w_next_state  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_redir) begin
                    w_next_state = i_imem_rvalid ? S_REQ : S_DROP;
                end else if (i_imem_rvalid) begin
                    w_next_if_valid = 1'b1;
                    w_next_if_pc    = r_req_pc;
                    w_next_if_instr = i_imem_rdata;
                    w_next_pc       = r_req_pc + ONE;
                    w_next_state    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_redir) begin
                    w_next_state = S_REQ;
                end else if (i_if_ready) begin
                    w_next_if_valid = 1'b0;
                    w_next_state    = S_REQ;
                end
            end
            S_DROP: begin
                // A response arriving together with a further redirect still
                // settles the only outstanding grant, so the fetch can resume.
                if (i_imem_rvalid) begin
                    w_next_state = S_REQ;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        if (w_redir) begin
            w_next_pc       = w_target;
            w_next_if_valid = 1'b0;
        end
    end

    // State register, updated on the falling edge like the rest of the PC logic.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            r_req_pc   <= w_next_req_pc;
            r_if_valid <= w_next_if_valid;
            r_if_pc    <= w_next_if_pc;
            r_if_instr <= w_next_if_instr;
        end
    end

    assign o_imem_req  = (r_state == S_REQ);
    assign o_imem_addr = r_pc;
    assign o_if_valid  = r_if_valid;
    assign o_if_pc     = r_if_pc;
    assign o_if_instr  = r_if_instr;
    assign o_cur_pc    = r_pc;

endmodule

// File: tb/tb_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_fetch_seq
// Directed bench for fetch_seq. A small memory responder grants requests and
// answers one cycle later (can be stalled); grants and deliveries to decode are
// logged into queues and compared with hand-computed addresses.
// Inputs change just after the rising edge, the DUT acts on the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_seq;

    logic        clk;
    logic        rst_n;
    logic        redir_valid;
    logic [1:0]  redir_type;
    logic        redir_taken;
    logic [31:0] redir_pc;
    logic [31:0] redir_offset;
    logic [31:0] redir_abs;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic [31:0] cur_pc;

    int errors = 0;
    int checks = 0;
    int badReq = 0;

    logic        pend;
    logic [31:0] pendAddr;
    logic        stall;
    logic [31:0] grants[$];
    logic [31:0] delivPc[$];
    logic [31:0] delivInstr[$];

    fetch_seq #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_redir_valid(redir_valid), .i_redir_type(redir_type),
        .i_redir_taken(redir_taken), .i_redir_pc(redir_pc),
        .i_redir_offset(redir_offset), .i_redir_abs(redir_abs),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_gnt(imem_gnt), .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
        .o_if_valid(if_valid), .o_if_pc(if_pc), .o_if_instr(if_instr),
        .i_if_ready(if_ready), .o_cur_pc(cur_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic logic effRedir();
        return redir_valid && ((redir_type == 2'b01 && redir_taken) || redir_type == 2'b10);
    endfunction

    // One clock: log what the coming falling edge will accept, then after the
    // rising edge drive the memory response for the next falling edge.
    task automatic applyStimulus();
        if (imem_req && imem_gnt) grants.push_back(imem_addr);
        if (if_valid && if_ready && !effRedir()) begin
            delivPc.push_back(if_pc);
            delivInstr.push_back(if_instr);
        end
        @(posedge clk);
        #1;
        if (imem_req && (if_valid || pend)) badReq++;
        if (pend && !stall) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instrOf(pendAddr);
            pend        = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
        end
        imem_gnt = imem_req && !pend && rst_n;
        if (imem_gnt) begin
            pend     = 1'b1;
            pendAddr = imem_addr;
        end
    endtask

    task automatic clearRedir();
        redir_valid = 1'b0; redir_type = 2'b00; redir_taken = 1'b0;
        redir_pc = '0; redir_offset = '0; redir_abs = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clearRedir();
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; if_ready = 1;
        pend = 0; pendAddr = 0; stall = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b req=%b pc=%h instr=%h, expected all zero",
                     if_valid, imem_req, if_pc, if_instr);
        end
        checks++;
        if (cur_pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_pc: got %h expected 00000000", cur_pc);
        end
        rst_n = 1'b1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got req=%b expected 0", imem_req);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 40 && delivPc.size() < 3; i++) applyStimulus();
        checks++;
        if (delivPc.size() < 3 || grants.size() < 3) begin
            errors++;
            $display("[TB] FAIL seq_timeout: got %0d deliveries expected 3", delivPc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (grants[i] !== 32'(i) || delivPc[i] !== 32'(i) || delivInstr[i] !== instrOf(32'(i))) begin
                    errors++;
                    $display("[TB] FAIL seq_item%0d: got addr=%h pc=%h instr=%h expected %h/%h/%h",
                             i, grants[i], delivPc[i], delivInstr[i], i, i, instrOf(32'(i)));
                end
            end
        end
        checks++;
        if (badReq !== 0) begin
            errors++;
            $display("[TB] FAIL req_in_wait_hold: got %0d bad cycles expected 0", badReq);
        end
    endtask

    task automatic test_backpressure();
        if_ready = 1'b0;
        for (int i = 0; i < 20 && !if_valid; i++) applyStimulus();
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'd3 || if_instr !== instrOf(32'd3) || imem_req !== 1'b0) begin
                errors++;
                $display("[TB] FAIL backpressure_c%0d: got valid=%b pc=%h instr=%h req=%b expected 1/3/%h/0",
                         i, if_valid, if_pc, if_instr, imem_req, instrOf(32'd3));
            end
        end
        if_ready = 1'b1;
        grants.delete();
        for (int i = 0; i < 20 && grants.size() == 0; i++) applyStimulus();
        checks++;
        if (grants.size() == 0 || grants[0] !== 32'd4) begin
            errors++;
            $display("[TB] FAIL backpressure_next: got %0d grants expected addr 4", grants.size());
        end
    endtask

    task automatic test_taken_branch();
        logic sawValid;
        delivPc.delete(); delivInstr.delete();
        for (int i = 0; i < 20 && delivPc.size() == 0; i++) applyStimulus();
        stall = 1'b1;
        grants.delete();
        for (int i = 0; i < 20 && grants.size() == 0; i++) applyStimulus();
        redir_valid = 1; redir_type = 2'b01; redir_taken = 1;
        redir_pc = 32'd10; redir_offset = 32'hFFFF_FFFC;
        applyStimulus();
        clearRedir();
        checks++;
        if (cur_pc !== 32'd7) begin
            errors++;
            $display("[TB] FAIL branch_target: got %h expected 00000007", cur_pc);
        end
        stall = 1'b0;
        grants.delete(); delivPc.delete(); delivInstr.delete();
        sawValid = 1'b0;
        for (int i = 0; i < 20 && grants.size() == 0; i++) begin
            applyStimulus();
            if (if_valid) sawValid = 1'b1;
        end
        checks++;
        if (grants.size() == 0 || grants[0] !== 32'd7 || sawValid !== 1'b0 || delivPc.size() != 0) begin
            errors++;
            $display("[TB] FAIL branch_drop: got grants=%0d sawValid=%b deliveries=%0d expected addr 7, no valid",
                     grants.size(), sawValid, delivPc.size());
        end
    endtask

    task automatic test_untaken_normal();
        redir_valid = 1; redir_type = 2'b01; redir_taken = 0;
        redir_pc = 32'd100; redir_offset = 32'd50; redir_abs = 32'h300;
        grants.delete();
        for (int i = 0; i < 30 && grants.size() < 2; i++) applyStimulus();
        checks++;
        if (grants.size() < 2 || grants[0] !== 32'd8 || grants[1] !== 32'd9) begin
            errors++;
            $display("[TB] FAIL untaken_branch: got %0d grants expected addresses 8,9", grants.size());
        end
        checks++;
        if (delivPc.size() == 0 || delivPc[0] !== 32'd7 || delivInstr[0] !== instrOf(32'd7)) begin
            errors++;
            $display("[TB] FAIL post_branch_deliver: got %0d deliveries expected pc 7", delivPc.size());
        end
        redir_type = 2'b00;
        grants.delete();
        for (int i = 0; i < 30 && grants.size() < 2; i++) applyStimulus();
        checks++;
        if (grants.size() < 2 || grants[0] !== 32'd10 || grants[1] !== 32'd11) begin
            errors++;
            $display("[TB] FAIL normal_type: got %0d grants expected addresses 10,11", grants.size());
        end
        clearRedir();
    endtask

    task automatic test_jump_hold();
        if_ready = 1'b0;
        for (int i = 0; i < 20 && !if_valid; i++) applyStimulus();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd11) begin
            errors++;
            $display("[TB] FAIL hold_before_jump: got valid=%b pc=%h expected 1/0000000b", if_valid, if_pc);
        end
        redir_valid = 1; redir_type = 2'b10; redir_abs = 32'h100;
        if_ready = 1'b1;
        delivPc.delete(); delivInstr.delete();
        applyStimulus();
        clearRedir();
        checks++;
        if (if_valid !== 1'b0 || cur_pc !== 32'h100 || delivPc.size() != 0) begin
            errors++;
            $display("[TB] FAIL jump_kill: got valid=%b pc=%h deliveries=%0d expected 0/00000100/0",
                     if_valid, cur_pc, delivPc.size());
        end
        grants.delete();
        for (int i = 0; i < 20 && delivPc.size() == 0; i++) applyStimulus();
        checks++;
        if (grants.size() == 0 || grants[0] !== 32'h100 || delivPc.size() == 0 ||
            delivPc[0] !== 32'h100 || delivInstr[0] !== instrOf(32'h100)) begin
            errors++;
            $display("[TB] FAIL jump_fetch: got grants=%0d deliveries=%0d expected addr/pc 00000100",
                     grants.size(), delivPc.size());
        end
    endtask

    task automatic test_wrap_reset();
        if_ready = 1'b0;
        for (int i = 0; i < 20 && !if_valid; i++) applyStimulus();
        redir_valid = 1; redir_type = 2'b01; redir_taken = 1;
        redir_pc = 32'hFFFF_FFFE; redir_offset = 32'd1;
        if_ready = 1'b1;
        applyStimulus();
        clearRedir();
        checks++;
        if (cur_pc !== 32'h0 || if_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_target: got pc=%h valid=%b expected 00000000/0", cur_pc, if_valid);
        end
        grants.delete(); delivPc.delete(); delivInstr.delete();
        for (int i = 0; i < 20 && delivPc.size() == 0; i++) applyStimulus();
        checks++;
        if (grants.size() == 0 || grants[0] !== 32'h0 || delivPc.size() == 0 || delivPc[0] !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_fetch: got grants=%0d deliveries=%0d expected addr/pc 0",
                     grants.size(), delivPc.size());
        end
        stall = 1'b1;
        grants.delete();
        for (int i = 0; i < 20 && grants.size() == 0; i++) applyStimulus();
        rst_n = 1'b0;
        pend = 0; imem_gnt = 0; imem_rvalid = 0; stall = 0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0 || cur_pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_in_wait: got valid=%b req=%b pc=%h expected 0/0/00000000",
                     if_valid, imem_req, cur_pc);
        end
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        if_ready = 1'b0;
        grants.delete();
        for (int i = 0; i < 20 && !if_valid; i++) applyStimulus();
        checks++;
        if (grants.size() == 0 || grants[0] !== 32'h0 || if_pc !== 32'h0 || if_instr !== instrOf(32'h0)) begin
            errors++;
            $display("[TB] FAIL restart_fetch: got grants=%0d pc=%h instr=%h expected addr/pc 0",
                     grants.size(), if_pc, if_instr);
        end
        rst_n = 1'b0;
        pend = 0; imem_gnt = 0; imem_rvalid = 0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_in_hold: got valid=%b pc=%h instr=%h expected all zero",
                     if_valid, if_pc, if_instr);
        end
        applyStimulus();
        rst_n = 1'b1;
    endtask

    initial begin
        $display("[TB] fetch_seq directed test start");
        test_reset();
        test_sequential();
        test_backpressure();
        test_taken_branch();
        test_untaken_normal();
        test_jump_hold();
        test_wrap_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
